// File: rtl/issue_trace_arbiter_pkg.sv
// Shared constants and types for the issue-trace arbiter: queue indices,
// widths and the saturating drop-counter increment.
package issue_trace_arbiter_pkg;

  localparam int Q_ALU   = 0;
  localparam int Q_MDU   = 1;
  localparam int Q_LSU   = 2;

  localparam int PC_W    = 32;
  localparam int DROP_W  = 16;
  localparam int QTYPE_W = 8;

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [DROP_W-1:0] drop_t;

  function automatic drop_t sat_inc(input drop_t c);
    return (&c) ? c : c + DROP_W'(1);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// DEPTH x PC_W event buffer; read/write pointers carry an extra phase bit so
// full and empty are distinguished without a separate count.
module trace_fifo
  import issue_trace_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  pc_t  din,
  output pc_t  dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr, rd_ptr;
  pc_t         mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // A push into a full FIFO that is popped the same cycle lands in the slot
  // being vacated; dout is read before the edge so the old entry still drains.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/issue_trace_arbiter.sv
// Collects per-issue-queue trace events into small FIFOs and serialises them
// round-robin into a single registered log stream, counting overflow drops.
module issue_trace_arbiter
  import issue_trace_arbiter_pkg::*;
#(
  parameter int NUM_Q = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trace_en,
  input  logic                     clear,
  input  logic [NUM_Q-1:0]         ev_valid,
  input  logic [PC_W*NUM_Q-1:0]    ev_pc,
  output logic                     log_en,
  output logic [PC_W-1:0]          log_pc,
  output logic [QTYPE_W-1:0]       log_queue_type,
  output logic [DROP_W*NUM_Q-1:0]  drop_cnt,
  output logic                     busy
);

  localparam int QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;

  logic [NUM_Q-1:0]        push_req, accept, drop, pop, full, empty;
  pc_t   [NUM_Q-1:0]       q_dout;
  drop_t [NUM_Q-1:0]       drop_q;
  logic [QW-1:0]           rr_ptr, gnt, rr_next;
  logic                    gnt_vld;
  int                      idx;

  // First non-empty queue scanning rr_ptr, rr_ptr+1, ... modulo NUM_Q.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    for (int off = 0; off < NUM_Q; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_Q) idx = idx - NUM_Q;
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld = 1'b1;
        gnt     = QW'(idx);
      end
    end
    if (clear) gnt_vld = 1'b0;
  end

  assign rr_next = (gnt == QW'(NUM_Q - 1)) ? '0 : gnt + QW'(1);
  assign busy    = ~&empty;

  for (genvar i = 0; i < NUM_Q; i++) begin : g_lane
    assign pop[i]      = gnt_vld && (gnt == QW'(i));
    assign push_req[i] = ev_valid[i] & trace_en & ~clear;
    assign accept[i]   = push_req[i] & (~full[i] | pop[i]);
    assign drop[i]     = push_req[i] & ~accept[i];

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .push  (accept[i]),
      .pop   (pop[i]),
      .din   (ev_pc[PC_W*i +: PC_W]),
      .dout  (q_dout[i]),
      .full  (full[i]),
      .empty (empty[i])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       drop_q[i] <= '0;
      else if (drop[i]) drop_q[i] <= sat_inc(drop_q[i]);
    end

    assign drop_cnt[DROP_W*i +: DROP_W] = drop_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      log_en         <= 1'b0;
      log_pc         <= '0;
      log_queue_type <= '0;
    end else begin
      if (clear)        rr_ptr <= '0;
      else if (gnt_vld) rr_ptr <= rr_next;
      log_en <= gnt_vld;
      if (gnt_vld) begin
        log_pc         <= q_dout[gnt];
        log_queue_type <= QTYPE_W'(gnt);
      end
    end
  end

endmodule

// File: tb/tb_issue_trace_arbiter.sv
// Randomised + directed bench: a queue-based reference model predicts each
// logged event into a scoreboard that a negedge monitor drains and compares.
module tb_issue_trace_arbiter;
  import issue_trace_arbiter_pkg::*;

  localparam int NUM_Q = 3;
  localparam int DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    trace_en = 1'b0;
  logic                    clear = 1'b0;
  logic [NUM_Q-1:0]        ev_valid = '0;
  logic [32*NUM_Q-1:0]     ev_pc = '0;
  logic                    log_en;
  logic [31:0]             log_pc;
  logic [7:0]              log_queue_type;
  logic [16*NUM_Q-1:0]     drop_cnt;
  logic                    busy;

  issue_trace_arbiter #(.NUM_Q(NUM_Q), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trace_en       (trace_en),
    .clear          (clear),
    .ev_valid       (ev_valid),
    .ev_pc          (ev_pc),
    .log_en         (log_en),
    .log_pc         (log_pc),
    .log_queue_type (log_queue_type),
    .drop_cnt       (drop_cnt),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [7:0] qt; } exp_t;

  logic [31:0] mq [NUM_Q][$];
  int          m_drop [NUM_Q];
  int          rr;
  bit          m_en, m_busy, chk_en;
  exp_t        exp_q [$];
  int          n_vec, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_Q; i++) begin
      mq[i].delete();
      m_drop[i] = 0;
    end
    rr = 0;
    exp_q.delete();
    m_en = 0;
    m_busy = 0;
  endtask

  // One clock of the spec's behaviour: grant on pre-edge contents, then pushes.
  task automatic model_step(input logic [NUM_Q-1:0] v, input logic [32*NUM_Q-1:0] pcs,
                            input bit en, input bit clr);
    int   g;
    bit   found;
    exp_t e;
    m_en = 0;
    if (clr) begin
      for (int i = 0; i < NUM_Q; i++) mq[i].delete();
      rr = 0;
    end else begin
      found = 0;
      g = 0;
      for (int off = 0; off < NUM_Q; off++)
        if (!found && mq[(rr + off) % NUM_Q].size() > 0) begin
          found = 1;
          g = (rr + off) % NUM_Q;
        end
      if (found) begin
        e.pc = mq[g].pop_front();
        e.qt = 8'(g);
        exp_q.push_back(e);
        m_en = 1;
        rr = (g + 1) % NUM_Q;
      end
      if (en)
        for (int i = 0; i < NUM_Q; i++)
          if (v[i]) begin
            if (mq[i].size() < DEPTH) mq[i].push_back(pcs[32*i +: 32]);
            else if (m_drop[i] < 16'hFFFF) m_drop[i]++;
          end
    end
    m_busy = 0;
    for (int i = 0; i < NUM_Q; i++) if (mq[i].size() > 0) m_busy = 1;
  endtask

  task automatic step(input logic [NUM_Q-1:0] v, input logic [32*NUM_Q-1:0] pcs,
                      input bit en, input bit clr);
    ev_valid = v;
    ev_pc    = pcs;
    trace_en = en;
    clear    = clr;
    @(posedge clk);
    #1;
    model_step(v, pcs, en, clr);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b1, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_log_en"}, 32'(log_en), 32'd0);
    chk({tag, "_log_pc"}, log_pc, 32'd0);
    chk({tag, "_log_qt"}, 32'(log_queue_type), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    for (int i = 0; i < NUM_Q; i++) chk({tag, "_drop"}, 32'(drop_cnt[16*i +: 16]), 32'd0);
  endtask

  // Monitor: checks the strobe every cycle and pops the scoreboard on each log.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("log_en", 32'(log_en), 32'(m_en));
      if (log_en) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL log_unexpected: got pc %0h type %0d expected none", log_pc, log_queue_type);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("log_pc", log_pc, e.pc);
          chk("log_queue_type", 32'(log_queue_type), 32'(e.qt));
        end
      end
      chk("busy", 32'(busy), 32'(m_busy));
      for (int i = 0; i < NUM_Q; i++)
        chk("drop_cnt", 32'(drop_cnt[16*i +: 16]), 32'(m_drop[i]));
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    chk_en = 0;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_en = 1;

    // Tracing disabled: nothing buffered, nothing dropped.
    for (int k = 0; k < 10; k++) step(3'b111, {$urandom, $urandom, $urandom}, 1'b0, 1'b0);

    // Single event, then idle.
    step(3'b001, {32'h0, 32'h0, 32'h1C000000}, 1'b1, 1'b0);
    idle(3);

    // Contention from rr_ptr=0.
    step('0, '0, 1'b1, 1'b1);
    step(3'b111, {32'h300, 32'h200, 32'h100}, 1'b1, 1'b0);
    idle(4);

    // Overflow: all queues saturated for 6 cycles, then drain.
    step('0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) step(3'b111, {$urandom, $urandom, $urandom}, 1'b1, 1'b0);
    idle(12);

    // Clear with three entries buffered.
    step(3'b111, {$urandom, $urandom, $urandom}, 1'b1, 1'b0);
    step(3'b111, {$urandom, $urandom, $urandom}, 1'b1, 1'b1);
    idle(3);

    // Random traffic.
    for (int k = 0; k < 400; k++)
      step(NUM_Q'($urandom), {$urandom, $urandom, $urandom},
           ($urandom_range(7) != 0), ($urandom_range(39) == 0));

    // Reset mid-drain: outputs drop immediately, buffered events vanish.
    step(3'b111, {$urandom, $urandom, $urandom}, 1'b1, 1'b0);
    step(3'b111, {$urandom, $urandom, $urandom}, 1'b1, 1'b0);
    #1;
    chk_en = 0;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    model_reset();
    ev_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_en = 1;
    step(3'b111, {32'hC, 32'hB, 32'hA}, 1'b1, 1'b0);
    idle(5);

    @(negedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
